pipeline_controller: RTL and testbench

- Sequences the core pipeline stages, including the s0 stage that feeds the pre-ALU operand registers.
- Generates the per-stage clk_enable strobes and tracks per-stage valid bits.
- Handles load/store stalls, single-cycle RAW bubbles, branch flushes and halt, with a watchdog on stall length.
- Sits between fetch, the load/store unit and the stage registers; purely control, no datapath.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/stall_watchdog.sv | 42 ++++
 rtl/pipeline_controller.sv | 130 +++++++++++++
 tb/tb_pipeline_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and width helpers for the pipeline controller and its stall watchdog.
package pipeline_pkg;

  typedef enum bit [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10,
    HALT  = 2'b11
  } pipe_state_e;

  localparam int MinCntW = 1;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_width(int max_val);
    return ($clog2(max_val + 1) < MinCntW) ? MinCntW : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Saturating stall-length counter with a sticky timeout flag.
module stall_watchdog
  import pipeline_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic timeout
);

  localparam int CntW = cnt_width(int'(STALL_TIMEOUT));
  localparam logic [CntW-1:0] CntMax = CntW'(STALL_TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (cnt_d == CntMax);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencing control: per-stage enables and valids, stalls, RAW bubbles,
// branch flushes, halt and a stall-length watchdog. No datapath.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned STAGES        = 4,
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic              mem_busy,
  input  logic              hazard_s0,
  input  logic              branch_taken,
  input  logic              halt_req,
  output logic [STAGES-1:0] stage_enable,
  output logic [STAGES-1:0] stage_valid,
  output logic              pc_load,
  output logic              halted,
  output logic              stall_timeout
);

  localparam int unsigned Last = STAGES - 1;
  localparam int FlushW = cnt_width(int'(FLUSH_CYCLES));
  localparam logic [FlushW-1:0] FlushLoad = FlushW'(FLUSH_CYCLES);

  pipe_state_e       state_q, state_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;

  logic branch_go, halt_go, bubble;

  // Redirects only count when the last stage really holds an instruction.
  assign branch_go = branch_taken & valid_q[Last];
  assign halt_go   = halt_req & valid_q[Last];
  assign bubble    = hazard_s0 & valid_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      valid_q     <= '0;
      halted_q    <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d = STALL;
        end else if (branch_go) begin
          valid_d     = '0;
          flush_cnt_d = FlushLoad;
          state_d     = FLUSH;
        end else if (halt_go) begin
          valid_d  = '0;
          halted_d = 1'b1;
          state_d  = HALT;
        end else if (bubble) begin
          // s0 holds, a bubble enters s1 and older stages keep moving.
          valid_d[0] = valid_q[0];
          valid_d[1] = 1'b0;
          for (int i = 2; i < STAGES; i++) valid_d[i] = valid_q[i-1];
        end else begin
          valid_d[0] = fetch_valid;
          for (int i = 1; i < STAGES; i++) valid_d[i] = valid_q[i-1];
        end
      end
      STALL: begin
        if (!mem_busy) state_d = RUN;
      end
      FLUSH: begin
        valid_d = '0;
        if (flush_cnt_q <= FlushW'(1)) begin
          state_d = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      HALT: begin
        halted_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    stage_enable = '0;
    fetch_ready  = 1'b0;
    pc_load      = 1'b0;
    if ((state_q == RUN) && !mem_busy) begin
      stage_enable = '1;
      if (branch_go) begin
        pc_load = 1'b1;
      end else if (halt_go) begin
        fetch_ready = 1'b0;
      end else if (bubble) begin
        stage_enable[0] = 1'b0;
      end else begin
        fetch_ready = 1'b1;
      end
    end
  end

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_stall_watchdog (
    .clk     (clk),
    .rst     (rst),
    .count_en(state_q == STALL),
    .clear   (state_q != STALL),
    .timeout (stall_timeout)
  );

  assign stage_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scenario bench for pipeline_controller (STAGES=4, FLUSH_CYCLES=1, STALL_TIMEOUT=2).
module tb_pipeline_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fetch_valid = 1'b0;
  logic       mem_busy = 1'b0;
  logic       hazard_s0 = 1'b0;
  logic       branch_taken = 1'b0;
  logic       halt_req = 1'b0;
  logic       fetch_ready;
  logic [3:0] stage_enable;
  logic [3:0] stage_valid;
  logic       pc_load;
  logic       halted;
  logic       stall_timeout;

  int n_chk  = 0;
  int n_pass = 0;

  // in = {fetch_valid, mem_busy, hazard_s0, branch_taken, halt_req}
  // fp = {fetch_ready, pc_load} this cycle; ht = {halted, stall_timeout} after the edge
  typedef struct {
    logic [4:0] in;
    logic [3:0] en;
    logic [1:0] fp;
    logic [3:0] vld;
    logic [1:0] ht;
  } step_t;

  step_t sb[$];

  pipeline_controller #(
    .STAGES       (4),
    .FLUSH_CYCLES (1),
    .STALL_TIMEOUT(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .mem_busy     (mem_busy),
    .hazard_s0    (hazard_s0),
    .branch_taken (branch_taken),
    .halt_req     (halt_req),
    .stage_enable (stage_enable),
    .stage_valid  (stage_valid),
    .pc_load      (pc_load),
    .halted       (halted),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(logic [4:0] in, logic [3:0] en, logic [1:0] fp,
                               logic [3:0] vld, logic [1:0] ht);
    step_t s;
    s.in  = in;
    s.en  = en;
    s.fp  = fp;
    s.vld = vld;
    s.ht  = ht;
    return s;
  endfunction

  task automatic drive(input step_t s);
    @(negedge clk);
    {fetch_valid, mem_busy, hazard_s0, branch_taken, halt_req} = s.in;
    sb.push_back(s);
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    n_chk++; if (stage_valid !== 4'b0000)
      $display("FAIL reset stage_valid got %b want 0000", stage_valid); else n_pass++;
    n_chk++; if ({halted, stall_timeout} !== 2'b00)
      $display("FAIL reset {halted,stall_timeout} got %b want 00", {halted, stall_timeout});
    else n_pass++;
    n_chk++; if (stage_enable !== 4'b1111)
      $display("FAIL reset stage_enable got %b want 1111", stage_enable); else n_pass++;
    n_chk++; if ({fetch_ready, pc_load} !== 2'b10)
      $display("FAIL reset {fetch_ready,pc_load} got %b want 10", {fetch_ready, pc_load});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill;
    step_t steps[$];
    step_t e;
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b0001, 2'b00));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b0011, 2'b00));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b0111, 2'b00));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b1111, 2'b00));
    foreach (steps[k]) begin
      drive(steps[k]);
      #1;
      e = sb.pop_front();
      n_chk++; if (stage_enable !== e.en)
        $display("FAIL fill[%0d] stage_enable got %b want %b", k, stage_enable, e.en);
      else n_pass++;
      n_chk++; if ({fetch_ready, pc_load} !== e.fp)
        $display("FAIL fill[%0d] {fetch_ready,pc_load} got %b want %b", k,
                 {fetch_ready, pc_load}, e.fp);
      else n_pass++;
      @(posedge clk);
      #1;
      n_chk++; if (stage_valid !== e.vld)
        $display("FAIL fill[%0d] stage_valid got %b want %b", k, stage_valid, e.vld);
      else n_pass++;
      n_chk++; if ({halted, stall_timeout} !== e.ht)
        $display("FAIL fill[%0d] {halted,stall_timeout} got %b want %b", k,
                 {halted, stall_timeout}, e.ht);
      else n_pass++;
    end
  endtask

  task automatic test_stall;
    step_t steps[$];
    step_t e;
    steps.push_back(mk(5'b11000, 4'b0000, 2'b00, 4'b1111, 2'b00));
    steps.push_back(mk(5'b11000, 4'b0000, 2'b00, 4'b1111, 2'b00));
    steps.push_back(mk(5'b11000, 4'b0000, 2'b00, 4'b1111, 2'b01));
    steps.push_back(mk(5'b10000, 4'b0000, 2'b00, 4'b1111, 2'b01));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b1111, 2'b01));
    foreach (steps[k]) begin
      drive(steps[k]);
      #1;
      e = sb.pop_front();
      n_chk++; if (stage_enable !== e.en)
        $display("FAIL stall[%0d] stage_enable got %b want %b", k, stage_enable, e.en);
      else n_pass++;
      n_chk++; if ({fetch_ready, pc_load} !== e.fp)
        $display("FAIL stall[%0d] {fetch_ready,pc_load} got %b want %b", k,
                 {fetch_ready, pc_load}, e.fp);
      else n_pass++;
      @(posedge clk);
      #1;
      n_chk++; if (stage_valid !== e.vld)
        $display("FAIL stall[%0d] stage_valid got %b want %b", k, stage_valid, e.vld);
      else n_pass++;
      n_chk++; if ({halted, stall_timeout} !== e.ht)
        $display("FAIL stall[%0d] {halted,stall_timeout} got %b want %b", k,
                 {halted, stall_timeout}, e.ht);
      else n_pass++;
    end
  endtask

  task automatic test_hazard;
    step_t steps[$];
    step_t e;
    steps.push_back(mk(5'b10100, 4'b1110, 2'b00, 4'b1101, 2'b01));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b1011, 2'b01));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b0111, 2'b01));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b1111, 2'b01));
    foreach (steps[k]) begin
      drive(steps[k]);
      #1;
      e = sb.pop_front();
      n_chk++; if (stage_enable !== e.en)
        $display("FAIL hazard[%0d] stage_enable got %b want %b", k, stage_enable, e.en);
      else n_pass++;
      n_chk++; if ({fetch_ready, pc_load} !== e.fp)
        $display("FAIL hazard[%0d] {fetch_ready,pc_load} got %b want %b", k,
                 {fetch_ready, pc_load}, e.fp);
      else n_pass++;
      @(posedge clk);
      #1;
      n_chk++; if (stage_valid !== e.vld)
        $display("FAIL hazard[%0d] stage_valid got %b want %b", k, stage_valid, e.vld);
      else n_pass++;
      n_chk++; if ({halted, stall_timeout} !== e.ht)
        $display("FAIL hazard[%0d] {halted,stall_timeout} got %b want %b", k,
                 {halted, stall_timeout}, e.ht);
      else n_pass++;
    end
  endtask

  // Branch redirect, one flush cycle (mem_busy ignored there), then hazard and
  // branch requests that must be ignored while their qualifying stage is empty.
  task automatic test_branch;
    step_t steps[$];
    step_t e;
    steps.push_back(mk(5'b10010, 4'b1111, 2'b01, 4'b0000, 2'b01));
    steps.push_back(mk(5'b11000, 4'b0000, 2'b00, 4'b0000, 2'b01));
    steps.push_back(mk(5'b10100, 4'b1111, 2'b10, 4'b0001, 2'b01));
    steps.push_back(mk(5'b10010, 4'b1111, 2'b10, 4'b0011, 2'b01));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b0111, 2'b01));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b1111, 2'b01));
    foreach (steps[k]) begin
      drive(steps[k]);
      #1;
      e = sb.pop_front();
      n_chk++; if (stage_enable !== e.en)
        $display("FAIL branch[%0d] stage_enable got %b want %b", k, stage_enable, e.en);
      else n_pass++;
      n_chk++; if ({fetch_ready, pc_load} !== e.fp)
        $display("FAIL branch[%0d] {fetch_ready,pc_load} got %b want %b", k,
                 {fetch_ready, pc_load}, e.fp);
      else n_pass++;
      @(posedge clk);
      #1;
      n_chk++; if (stage_valid !== e.vld)
        $display("FAIL branch[%0d] stage_valid got %b want %b", k, stage_valid, e.vld);
      else n_pass++;
      n_chk++; if ({halted, stall_timeout} !== e.ht)
        $display("FAIL branch[%0d] {halted,stall_timeout} got %b want %b", k,
                 {halted, stall_timeout}, e.ht);
      else n_pass++;
    end
  endtask

  task automatic test_branch_halt;
    step_t steps[$];
    step_t e;
    steps.push_back(mk(5'b10011, 4'b1111, 2'b01, 4'b0000, 2'b01));
    steps.push_back(mk(5'b00001, 4'b0000, 2'b00, 4'b0000, 2'b01));
    steps.push_back(mk(5'b10001, 4'b1111, 2'b10, 4'b0001, 2'b01));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b0011, 2'b01));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b0111, 2'b01));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b1111, 2'b01));
    steps.push_back(mk(5'b10001, 4'b1111, 2'b00, 4'b0000, 2'b11));
    steps.push_back(mk(5'b10010, 4'b0000, 2'b00, 4'b0000, 2'b11));
    steps.push_back(mk(5'b11000, 4'b0000, 2'b00, 4'b0000, 2'b11));
    steps.push_back(mk(5'b10000, 4'b0000, 2'b00, 4'b0000, 2'b11));
    foreach (steps[k]) begin
      drive(steps[k]);
      #1;
      e = sb.pop_front();
      n_chk++; if (stage_enable !== e.en)
        $display("FAIL halt[%0d] stage_enable got %b want %b", k, stage_enable, e.en);
      else n_pass++;
      n_chk++; if ({fetch_ready, pc_load} !== e.fp)
        $display("FAIL halt[%0d] {fetch_ready,pc_load} got %b want %b", k,
                 {fetch_ready, pc_load}, e.fp);
      else n_pass++;
      @(posedge clk);
      #1;
      n_chk++; if (stage_valid !== e.vld)
        $display("FAIL halt[%0d] stage_valid got %b want %b", k, stage_valid, e.vld);
      else n_pass++;
      n_chk++; if ({halted, stall_timeout} !== e.ht)
        $display("FAIL halt[%0d] {halted,stall_timeout} got %b want %b", k,
                 {halted, stall_timeout}, e.ht);
      else n_pass++;
    end
    // Mid-cycle reset out of HALT must act without waiting for a clock edge.
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({halted, stall_timeout} !== 2'b00)
      $display("FAIL halt_rst {halted,stall_timeout} got %b want 00", {halted, stall_timeout});
    else n_pass++;
    n_chk++; if (stage_enable !== 4'b1111)
      $display("FAIL halt_rst stage_enable got %b want 1111", stage_enable); else n_pass++;
    n_chk++; if ({fetch_ready, pc_load} !== 2'b10)
      $display("FAIL halt_rst {fetch_ready,pc_load} got %b want 10", {fetch_ready, pc_load});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_rst_stall;
    step_t steps[$];
    step_t post[$];
    step_t e;
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b0001, 2'b00));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b0011, 2'b00));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b0111, 2'b00));
    steps.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b1111, 2'b00));
    steps.push_back(mk(5'b11000, 4'b0000, 2'b00, 4'b1111, 2'b00));
    steps.push_back(mk(5'b11000, 4'b0000, 2'b00, 4'b1111, 2'b00));
    // After reset one stall cycle must not trip a timeout of 2: the counter restarted at 0.
    post.push_back(mk(5'b01000, 4'b0000, 2'b00, 4'b0000, 2'b00));
    post.push_back(mk(5'b01000, 4'b0000, 2'b00, 4'b0000, 2'b00));
    post.push_back(mk(5'b00000, 4'b0000, 2'b00, 4'b0000, 2'b01));
    post.push_back(mk(5'b10000, 4'b1111, 2'b10, 4'b0001, 2'b01));
    foreach (steps[k]) begin
      drive(steps[k]);
      #1;
      e = sb.pop_front();
      n_chk++; if (stage_enable !== e.en)
        $display("FAIL rst_stall[%0d] stage_enable got %b want %b", k, stage_enable, e.en);
      else n_pass++;
      n_chk++; if ({fetch_ready, pc_load} !== e.fp)
        $display("FAIL rst_stall[%0d] {fetch_ready,pc_load} got %b want %b", k,
                 {fetch_ready, pc_load}, e.fp);
      else n_pass++;
      @(posedge clk);
      #1;
      n_chk++; if (stage_valid !== e.vld)
        $display("FAIL rst_stall[%0d] stage_valid got %b want %b", k, stage_valid, e.vld);
      else n_pass++;
      n_chk++; if ({halted, stall_timeout} !== e.ht)
        $display("FAIL rst_stall[%0d] {halted,stall_timeout} got %b want %b", k,
                 {halted, stall_timeout}, e.ht);
      else n_pass++;
    end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (stage_valid !== 4'b0000)
      $display("FAIL rst_stall_async stage_valid got %b want 0000", stage_valid); else n_pass++;
    n_chk++; if (stage_enable !== 4'b0000)
      $display("FAIL rst_stall_async stage_enable got %b want 0000", stage_enable); else n_pass++;
    n_chk++; if ({fetch_ready, pc_load} !== 2'b00)
      $display("FAIL rst_stall_async {fetch_ready,pc_load} got %b want 00",
               {fetch_ready, pc_load});
    else n_pass++;
    rst = 1'b0;
    foreach (post[k]) begin
      drive(post[k]);
      #1;
      e = sb.pop_front();
      n_chk++; if (stage_enable !== e.en)
        $display("FAIL rst_post[%0d] stage_enable got %b want %b", k, stage_enable, e.en);
      else n_pass++;
      n_chk++; if ({fetch_ready, pc_load} !== e.fp)
        $display("FAIL rst_post[%0d] {fetch_ready,pc_load} got %b want %b", k,
                 {fetch_ready, pc_load}, e.fp);
      else n_pass++;
      @(posedge clk);
      #1;
      n_chk++; if (stage_valid !== e.vld)
        $display("FAIL rst_post[%0d] stage_valid got %b want %b", k, stage_valid, e.vld);
      else n_pass++;
      n_chk++; if ({halted, stall_timeout} !== e.ht)
        $display("FAIL rst_post[%0d] {halted,stall_timeout} got %b want %b", k,
                 {halted, stall_timeout}, e.ht);
      else n_pass++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout bench did not complete, checks %0d passed %0d", n_chk, n_pass);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_hazard();
    test_branch();
    test_branch_halt();
    test_rst_stall();
    n_chk++; if (sb.size() != 0)
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
